// File: rtl/rd_port_arbiter.sv
// rd_port_arbiter: shares one FWFT FIFO read port among three consumers.
// Round-robin grant in IDLE, bounded-length burst of pops in BURST, with a
// mandatory one-cycle arbitration bubble between consecutive bursts.
module rd_port_arbiter #(
    parameter int BURST_MAX = 4,   // words per grant, 1..8
    parameter int DW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_empty,
    input  logic          fifo_almost_empty,
    input  logic [DW-1:0] fifo_rdata,
    output logic          fifo_r_en,
    input  logic [2:0]    req,
    output logic [2:0]    gnt,
    output logic [DW-1:0] dout,
    output logic [2:0]    dout_valid,
    output logic          busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [3:0] LIMIT_MAX = 4'(BURST_MAX);

    state_t     state, state_nxt;
    logic [2:0] gnt_nxt;
    logic [1:0] last_owner;
    logic [1:0] pick;
    logic [2:0] cnt;
    logic [3:0] burst_limit;
    logic       owner_req;
    logic       grant;
    logic       pop;
    logic       burst_end;

    // The owner is identified by the one-hot gnt, so its request is a mask-and-reduce.
    assign owner_req = |(req & gnt);
    assign grant     = (state == IDLE) && !fifo_empty && (|req);
    assign pop       = (state == BURST) && owner_req && !fifo_empty;
    assign burst_end = (state == BURST) &&
                       ((pop && ({1'b0, cnt} == burst_limit - 4'd1)) || !owner_req || fifo_empty);
    assign fifo_r_en = pop;
    assign busy      = (state == BURST);

    // Round-robin pick: scan the three slots after last_owner; the nearest set bit wins,
    // so the scan runs farthest-first and nearer hits overwrite.
    always_comb begin
        logic [1:0] idx;
        idx  = 2'd0;
        pick = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            idx = 2'((32'(last_owner) + 32'(k)) % 32'd3);
            if (req[idx]) pick = idx;
        end
    end

    // Next-state and next-grant: grant on entering BURST, clear on any exit.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        case (state)
            IDLE: begin
                gnt_nxt = 3'b000;
                if (grant) begin
                    state_nxt = BURST;
                    gnt_nxt   = 3'b001 << pick;
                end
            end
            BURST: begin
                if (burst_end) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 3'b000;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 3'b000;
            end
        endcase
    end

    // State and grant registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            gnt   <= 3'b000;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
        end
    end

    // Per-grant bookkeeping: owner history, burst length, word counter.
    // The counter holds on the final pop so it never wraps inside a burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner  <= 2'd2;
            burst_limit <= LIMIT_MAX;
            cnt         <= 3'd0;
        end else if (grant) begin
            last_owner  <= pick;
            burst_limit <= fifo_almost_empty ? 4'd1 : LIMIT_MAX;
            cnt         <= 3'd0;
        end else if (pop && !burst_end) begin
            cnt <= cnt + 3'd1;
        end
    end

    // Output register: capture the head word on each pop, tagged with its owner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 3'b000;
        end else begin
            dout_valid <= pop ? gnt : 3'b000;
            if (pop) dout <= fifo_rdata;
        end
    end

endmodule
